// File: rtl/bcd_chain_ctrl.sv
`timescale 1ns/1ps
// Run controller for a cascade of external BCD digit counters: prescaled count
// tick, carry-chained per-digit enables, broadcast clear and terminal-count handling.
module bcd_chain_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 10
) (
    input  logic                c,
    input  logic                rst,
    input  logic                start,
    input  logic                pause,
    input  logic                clr,
    input  logic                auto_reload,
    input  logic [4*DIGITS-1:0] target,
    input  logic [4*DIGITS-1:0] q,
    output logic [DIGITS-1:0]   cnt_en,
    output logic                cnt_clr,
    output logic                tick,
    output logic [1:0]          state,
    output logic                busy,
    output logic                done,
    output logic                err
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    state_t        st;
    logic [PW-1:0] presc;
    logic          term;
    logic          run_tick;
    logic          chain;

    function automatic logic digit_nine(input logic [4*DIGITS-1:0] v, input int i);
        return v[4*i +: 4] == 4'd9;
    endfunction

    function automatic logic any_bad_digit(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | (v[4*i +: 4] > 4'd9);
        end
        return bad;
    endfunction

    assign term     = (q == target);
    assign state    = st;
    assign run_tick = tick & (st == RUN) & ~clr & ~pause;

    // Decimal carry ripples combinationally: digit i counts only when all lower digits read 9.
    always_comb begin
        cnt_en = '0;
        chain  = run_tick & ~term;
        for (int i = 0; i < DIGITS; i++) begin
            cnt_en[i] = chain;
            chain     = chain & digit_nine(q, i);
        end
    end

    always_ff @(posedge c or negedge rst) begin
        if (!rst) begin
            st      <= IDLE;
            presc   <= '0;
            tick    <= 1'b0;
            cnt_clr <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            tick    <= 1'b0;
            cnt_clr <= 1'b0;
            done    <= 1'b0;
            if (clr) begin
                st      <= IDLE;
                busy    <= 1'b0;
                presc   <= '0;
                err     <= 1'b0;
                cnt_clr <= 1'b1;
            end else begin
                if (st == RUN && any_bad_digit(q)) begin
                    err <= 1'b1;
                end
                case (st)
                    IDLE: begin
                        if (start && !pause) begin
                            st    <= RUN;
                            busy  <= 1'b1;
                            presc <= '0;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            // Prescaler freezes here so counting resumes mid-period.
                            st   <= PAUSE;
                            busy <= 1'b0;
                        end else if (tick && term && !auto_reload) begin
                            st   <= DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            if (tick && term) begin
                                done    <= 1'b1;
                                cnt_clr <= 1'b1;
                            end
                            if (presc == PMAX) begin
                                presc <= '0;
                                tick  <= 1'b1;
                            end else begin
                                presc <= presc + PW'(1);
                            end
                        end
                    end
                    PAUSE: begin
                        if (start && !pause) begin
                            st   <= RUN;
                            busy <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (start && !pause) begin
                            st      <= RUN;
                            busy    <= 1'b1;
                            presc   <= '0;
                            cnt_clr <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bcd_chain_ctrl.sv
`timescale 1ns/1ps
// Bench for bcd_chain_ctrl: reset/sequence table, directed corner cases and a
// randomized run against an arithmetic reference model of controller plus counters.
module tb_bcd_chain_ctrl;
    localparam int DIGITS = 4;
    localparam int DIV    = 4;

    logic        c = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, pause = 1'b0, clr = 1'b0, auto_reload = 1'b0;
    logic [15:0] target = 16'h9999;
    logic [15:0] q;
    logic [3:0]  cnt_en;
    logic        cnt_clr, tick, busy, done, err;
    logic [1:0]  state;

    logic        ld = 1'b0;
    logic [15:0] ld_val = 16'h0;
    logic [15:0] q_cnt = 16'h0;

    int total = 0;
    int bad   = 0;

    bcd_chain_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .c(c), .rst(rst), .start(start), .pause(pause), .clr(clr),
        .auto_reload(auto_reload), .target(target), .q(q),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr), .tick(tick), .state(state),
        .busy(busy), .done(done), .err(err)
    );

    always #5 c = ~c;

    // External digit counters, with a bench-side load for forcing values.
    assign q = q_cnt;
    always @(posedge c) begin
        if (ld) q_cnt <= ld_val;
        else if (cnt_clr) q_cnt <= 16'h0;
        else begin
            for (int i = 0; i < 4; i++)
                if (cnt_en[i]) q_cnt[4*i +: 4] <= (q_cnt[4*i +: 4] == 4'd9) ? 4'd0 : q_cnt[4*i +: 4] + 4'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge c); #1; end
    endtask

    task automatic wait_tick(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge c); #1;
            if (tick) begin n = i; break; end
        end
    endtask

    task automatic load_q(input logic [15:0] v);
        ld = 1'b1; ld_val = v;
        @(posedge c); #1;
        ld = 1'b0;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    typedef struct {
        logic st, pa, cl;
        logic [1:0] e_state;
        logic e_tick, e_clr, e_busy;
        logic [15:0] e_q;
    } vec_t;
    vec_t tbl[17];

    // Reference model state
    int m_st, m_ph, m_n, t_int;
    bit m_tick, m_clr, m_done, m_err;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, nd, t1, t2, tv;
        bit stayed, mterm, en_any, nt, nc, ndn;
        logic [15:0] qh;
        logic [3:0] e_en;
        int v, n_next;

        tbl[0]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 16'h0000};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 16'h0000};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 16'h0000};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 16'h0000};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 16'h0001};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0001};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0001};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 16'h0001};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 16'h0001};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 16'h0001};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 16'h0001};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 16'h0002};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0002};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000};

        cyc(2);
        check("reset_state", 32'(state), 32'd0);
        check("reset_flags", {tick, cnt_clr, done, err, busy}, 32'd0);
        check("reset_en", 32'(cnt_en), 32'd0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            start = tbl[i].st; pause = tbl[i].pa; clr = tbl[i].cl;
            cyc(1);
            check($sformatf("table_row%0d", i), {state, tick, cnt_clr, busy, done, q},
                  {tbl[i].e_state, tbl[i].e_tick, tbl[i].e_clr, tbl[i].e_busy, 1'b0, tbl[i].e_q});
        end
        start = 1'b0; pause = 1'b0; clr = 1'b0;

        // Stop at target 12
        target = 16'h0012; auto_reload = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        nd = 0; t1 = 0;
        for (int i = 1; i <= 100; i++) begin
            cyc(1);
            if (done) begin
                nd++; t1 = i;
                check("stop_q_at_done", 32'(q), 32'h0012);
            end
        end
        check("stop_done_count", nd, 1);
        check("stop_done_time", t1, 53);
        check("stop_final", {state, busy, cnt_en, q}, {2'd3, 1'b0, 4'b0, 16'h0012});

        // Auto-reload at target 12, restarting from DONE
        auto_reload = 1'b1;
        start = 1'b1; cyc(1); start = 1'b0;
        check("reload_restart", {state, cnt_clr}, {2'd1, 1'b1});
        nd = 0; t1 = 0; t2 = 0; stayed = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            cyc(1);
            if (state != 2'd1) stayed = 1'b0;
            if (nd == 1 && i == t1 + 1) check("reload_q_zero", 32'(q), 32'h0);
            if (done) begin
                nd++;
                if (nd == 1) t1 = i; else t2 = i;
                check("reload_clr_with_done", 32'(cnt_clr), 32'd1);
            end
        end
        check("reload_done_count", nd, 2);
        check("reload_times", {t1[15:0], t2[15:0]}, {16'd53, 16'd105});
        check("reload_stayed_run", 32'(stayed), 32'd1);

        // Carry ripple 0999 -> 1000, then wrap 9999 -> 0000 with no match
        clr = 1'b1; cyc(1); clr = 1'b0; auto_reload = 1'b0; target = 16'h9999;
        cyc(1);
        start = 1'b1; cyc(1); start = 1'b0;
        wait_tick(n);
        check("carry_tick_seen", 32'(n > 0), 32'd1);
        load_q(16'h0999); cyc(2); cyc(1);
        check("carry_en", {tick, cnt_en}, {1'b1, 4'b1111});
        cyc(1);
        check("carry_q", 32'(q), 32'h1000);
        target = 16'h5000;
        wait_tick(n);
        load_q(16'h9999); cyc(2); cyc(1);
        check("wrap_en", {tick, cnt_en}, {1'b1, 4'b1111});
        cyc(1);
        check("wrap_q", {done, q}, {1'b0, 16'h0000});
        cyc(1);
        check("wrap_no_done", 32'(done), 32'd0);

        // Pause at prescaler 2 for 7 cycles
        wait_tick(n);
        cyc(2);
        qh = q;
        pause = 1'b1; nd = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            if (tick) nd++;
        end
        check("pause_no_ticks", nd, 0);
        check("pause_state", 32'(state), 32'd2);
        pause = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
        check("resume_t1", 32'(tick), 32'd0);
        cyc(1);
        check("resume_t2", 32'(tick), 32'd0);
        cyc(1);
        check("resume_t3", 32'(tick), 32'd1);
        check("pause_q_held", 32'(q), 32'(qh));

        // Pause on a tick cycle drops the tick
        wait_tick(n);
        pause = 1'b1; #1;
        check("pause_tick_en", 32'(cnt_en), 32'd0);
        qh = q;
        cyc(1);
        check("pause_tick_state", {state, q}, {2'd2, qh});
        pause = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
        wait_tick(n);
        check("pause_tick_resume_gap", n, 4);

        // clr + start + pause on a tick cycle: clear wins
        clr = 1'b1; start = 1'b1; pause = 1'b1; #1;
        check("clr_tick_en", 32'(cnt_en), 32'd0);
        cyc(1);
        clr = 1'b0; start = 1'b0; pause = 1'b0;
        check("clr_wins", {state, cnt_clr, busy}, {2'd0, 1'b1, 1'b0});

        // Sticky err on a non-BCD digit
        start = 1'b1; cyc(1); start = 1'b0;
        load_q(16'h00B0);
        cyc(1);
        check("err_set", 32'(err), 32'd1);
        load_q(16'h0000); cyc(3);
        check("err_sticky", 32'(err), 32'd1);
        clr = 1'b1; cyc(1); clr = 1'b0;
        check("err_cleared", {state, err}, {2'd0, 1'b0});

        // Asynchronous reset mid-count, during a tick cycle
        start = 1'b1; cyc(1); start = 1'b0;
        wait_tick(n);
        #2 rst = 1'b0; #1;
        check("rst_async", {state, tick, cnt_clr, done, err, busy, cnt_en}, 32'd0);
        qh = q;
        @(posedge c); #1; rst = 1'b1;
        cyc(2);
        check("rst_after", {state, q}, {2'd0, qh});

        // Randomized run against the reference model
        ld = 1'b1; ld_val = 16'h0; rst = 1'b0;
        @(posedge c); #1;
        ld = 1'b0; rst = 1'b1;
        m_st = 0; m_ph = 0; m_n = 0; t_int = -1;
        m_tick = 0; m_clr = 0; m_done = 0; m_err = 0;
        for (k = 0; k < 3000; k++) begin
            if (k % 300 == 0) begin
                tv = int'($urandom_range(0, 25));
                if ($urandom_range(0, 4) == 0) begin target = 16'h00A5; t_int = -1; end
                else begin target = to_bcd(tv); t_int = tv; end
                auto_reload = 1'($urandom_range(0, 1));
            end
            clr   = ($urandom_range(0, 99) < 1);
            pause = ($urandom_range(0, 99) < 6);
            start = ($urandom_range(0, 99) < 30);
            #1;
            mterm  = (m_n == t_int);
            en_any = m_tick && (m_st == 1) && !mterm && !clr && !pause;
            e_en = 4'b0;
            if (en_any) begin
                v = m_n;
                for (int i = 0; i < DIGITS; i++) begin
                    e_en[i] = 1'b1;
                    if (v % 10 != 9) break;
                    v = v / 10;
                end
            end
            check("random", {state, tick, cnt_clr, done, err, busy, cnt_en, q},
                  {2'(m_st), m_tick, m_clr, m_done, m_err, (m_st == 1), e_en, to_bcd(m_n)});

            n_next = m_n;
            if (m_clr) n_next = 0;
            else if (en_any) n_next = (m_n + 1) % 10000;
            nt = 0; nc = 0; ndn = 0;
            if (clr) begin
                m_st = 0; m_ph = 0; m_err = 0; nc = 1;
            end else begin
                case (m_st)
                    0: if (start && !pause) begin m_st = 1; m_ph = 0; end
                    2: if (start && !pause) m_st = 1;
                    3: if (start && !pause) begin m_st = 1; m_ph = 0; nc = 1; end
                    default: begin
                        if (pause) m_st = 2;
                        else if (m_tick && mterm && !auto_reload) begin m_st = 3; ndn = 1; end
                        else begin
                            if (m_tick && mterm) begin ndn = 1; nc = 1; end
                            m_ph = m_ph + 1;
                            if (m_ph == DIV) begin m_ph = 0; nt = 1; end
                        end
                    end
                endcase
            end
            m_tick = nt; m_clr = nc; m_done = ndn; m_n = n_next;
            @(posedge c); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
